// File: rtl/fir_l3_output_serializer_if.sv
// rtl/fir_l3_output_serializer_if.sv - block-in / sample-out bundle for the L3 FIR output serializer
//
// Ports carried:
//   in_valid/in_ready               block handshake (upstream filter -> serializer)
//   in_data_1..in_data_3            three signed full-precision filter outputs, emitted 1,2,3
//   out_valid/out_ready             serial sample handshake (serializer -> downstream)
//   out_data                        rounded/saturated signed sample
//   out_phase                       position of out_data within its block (0..2)
//   sat_flag, drop_flag             sticky status
//   flag_clr                        synchronous clear of the sticky status
// slave modport is the serializer side, master modport the driving side.

interface fir_l3_output_serializer_if #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [IN_WIDTH-1:0]  in_data_1;
    logic signed [IN_WIDTH-1:0]  in_data_2;
    logic signed [IN_WIDTH-1:0]  in_data_3;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic [1:0]                  out_phase;
    logic                        sat_flag;
    logic                        drop_flag;
    logic                        flag_clr;

    modport slave (
        input  in_valid, in_data_1, in_data_2, in_data_3, out_ready, flag_clr,
        output in_ready, out_valid, out_data, out_phase, sat_flag, drop_flag
    );

    modport master (
        output in_valid, in_data_1, in_data_2, in_data_3, out_ready, flag_clr,
        input  in_ready, out_valid, out_data, out_phase, sat_flag, drop_flag
    );
endinterface

// File: rtl/fir_l3_output_serializer.sv
// rtl/fir_l3_output_serializer.sv - buffers 3-sample FIR blocks and emits rounded/saturated samples serially
//
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      fir_l3_output_serializer_if.slave (block input, sample output, sticky flags)
// Parameters:
//   IN_WIDTH    width of each parallel filter output
//   OUT_WIDTH   width of the serial output sample
//   SHIFT       fractional bits removed before rounding (1..IN_WIDTH-1)
//   FIFO_DEPTH  capacity in blocks, power of 2, >= 2

module fir_l3_output_serializer #(
    parameter int IN_WIDTH   = 64,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 23,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    fir_l3_output_serializer_if.slave     bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef logic signed [IN_WIDTH-1:0] samp_t;
    typedef logic signed [IN_WIDTH:0]   wide_t;

    // Rounding is done one bit wider than the input so x + half can never wrap.
    localparam wide_t HALF  = wide_t'(1) <<< (SHIFT - 1);
    localparam wide_t MAX_W = {{(IN_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam wide_t MIN_W = {{(IN_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] MAX_O = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MIN_O = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    samp_t mem_q [FIFO_DEPTH][3];
    samp_t mem_d [FIFO_DEPTH][3];

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [1:0]           phase_q, phase_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]           out_phase_q, out_phase_d;
    logic                 sat_q, sat_d;
    logic                 drop_q, drop_d;

    logic                 in_ready;
    logic                 push;
    logic                 load;
    logic                 pop;
    samp_t                head;
    wide_t                rnd;
    wide_t                shr;
    logic                 sat_hi;
    logic                 sat_lo;
    logic [OUT_WIDTH-1:0] conv_data;

    // Acceptance looks at occupancy only; a pop in the same cycle does not free a slot.
    assign in_ready = (count_q < CW'(FIFO_DEPTH));
    assign push     = bus.in_valid && in_ready;
    assign load     = (!out_valid_q || bus.out_ready) && (count_q != '0);
    assign pop      = load && (phase_q == 2'd2);

    always_comb begin
        head = '0;
        case (phase_q)
            2'd0:    head = mem_q[rd_ptr_q][0];
            2'd1:    head = mem_q[rd_ptr_q][1];
            default: head = mem_q[rd_ptr_q][2];
        endcase
    end

    always_comb begin
        rnd    = wide_t'(head) + HALF;
        shr    = rnd >>> SHIFT;
        sat_hi = (shr > MAX_W);
        sat_lo = (shr < MIN_W);
        if (sat_hi) begin
            conv_data = MAX_O;
        end else if (sat_lo) begin
            conv_data = MIN_O;
        end else begin
            conv_data = shr[OUT_WIDTH-1:0];
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q][0] = bus.in_data_1;
            mem_d[wr_ptr_q][1] = bus.in_data_2;
            mem_d[wr_ptr_q][2] = bus.in_data_3;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        phase_d     = phase_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_phase_d = out_phase_q;
        sat_d       = sat_q;
        drop_d      = drop_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = conv_data;
            out_phase_d = phase_q;
            if (phase_q == 2'd2) begin
                phase_d  = 2'd0;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                phase_d = phase_q + 2'd1;
            end
        end else if (!out_valid_q || bus.out_ready) begin
            // Output slot is free but nothing is buffered: go idle, data holds.
            out_valid_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (bus.flag_clr) begin
            sat_d  = 1'b0;
            drop_d = 1'b0;
        end else begin
            sat_d  = sat_q  || (load && (sat_hi || sat_lo));
            drop_d = drop_q || (bus.in_valid && !in_ready);
        end
    end

    // Storage carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            phase_q     <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_phase_q <= 2'd0;
            sat_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            phase_q     <= phase_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_phase_q <= out_phase_d;
            sat_q       <= sat_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_phase = out_phase_q;
    assign bus.sat_flag  = sat_q;
    assign bus.drop_flag = drop_q;
endmodule

// File: tb/tb_fir_l3_output_serializer.sv
// tb/tb_fir_l3_output_serializer.sv - self-checking bench for fir_l3_output_serializer

module tb_fir_l3_output_serializer;
    localparam int IW = 64;
    localparam int OW = 16;
    localparam int SH = 23;
    localparam int FD = 4;

    typedef logic signed [IW-1:0] samp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fir_l3_output_serializer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    fir_l3_output_serializer #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: flat queue of buffered samples (head block first, already-emitted
    // samples of the head removed). Blocks occupying the FIFO = ceil(size/3).
    samp_t          mq[$];
    logic [OW-1:0]  exp_s[$];
    logic [OW-1:0]  got_s[$];
    bit             m_valid;
    bit             m_sat;
    bit             m_drop;
    logic [OW-1:0]  m_data;
    logic [1:0]     m_phase;

    function automatic logic [OW-1:0] conv(input samp_t x, output bit sat);
        logic signed [IW:0] t;
        t   = x;
        t   = t + (65'sd1 <<< (SH - 1));
        t   = t >>> SH;
        sat = 1'b0;
        if (t > 65'sd32767) begin
            sat = 1'b1;
            return 16'h7fff;
        end
        if (t < -65'sd32768) begin
            sat = 1'b1;
            return 16'h8000;
        end
        return t[OW-1:0];
    endfunction

    function automatic samp_t rand_samp();
        samp_t r;
        r = {$urandom, $urandom};
        r = r >>> $urandom_range(20, 45);
        return r;
    endfunction

    function automatic bit model_ready();
        return ((mq.size() + 2) / 3) < FD;
    endfunction

    task automatic model_clear();
        mq.delete();
        exp_s.delete();
        got_s.delete();
        m_valid = 1'b0;
        m_sat   = 1'b0;
        m_drop  = 1'b0;
        m_data  = '0;
        m_phase = 2'd0;
    endtask

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.in_data_1 = '0;
        bus.in_data_2 = '0;
        bus.in_data_3 = '0;
        bus.out_ready = 1'b0;
        bus.flag_clr  = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_block(input samp_t a, input samp_t b, input samp_t c);
        bus.in_valid  = 1'b1;
        bus.in_data_1 = a;
        bus.in_data_2 = b;
        bus.in_data_3 = c;
    endtask

    // One clock: model next state from current inputs, then edge, then settle.
    task automatic step();
        bit            rdy, push, drop, slot, load, se, dummy;
        logic [OW-1:0] cv;
        logic [1:0]    ph;
        bit            nv;
        samp_t         x;
        rdy  = model_ready();
        push = bus.in_valid && rdy;
        drop = bus.in_valid && !rdy;
        slot = !m_valid || bus.out_ready;
        load = slot && (mq.size() > 0);
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got_s.push_back(bus.out_data);
        se = 1'b0;
        cv = m_data;
        ph = m_phase;
        nv = m_valid;
        if (load) begin
            ph = 2'((3 - (mq.size() % 3)) % 3);
            x  = mq.pop_front();
            cv = conv(x, se);
            nv = 1'b1;
        end else if (slot) begin
            nv = 1'b0;
        end
        if (push) begin
            mq.push_back(bus.in_data_1);
            mq.push_back(bus.in_data_2);
            mq.push_back(bus.in_data_3);
            exp_s.push_back(conv(bus.in_data_1, dummy));
            exp_s.push_back(conv(bus.in_data_2, dummy));
            exp_s.push_back(conv(bus.in_data_3, dummy));
        end
        @(posedge clk);
        m_valid = nv;
        m_data  = cv;
        m_phase = ph;
        if (bus.flag_clr) begin
            m_sat  = 1'b0;
            m_drop = 1'b0;
        end else begin
            m_sat  = m_sat || (load && se);
            m_drop = m_drop || drop;
        end
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        reset_n = 1'b0;
        #3;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 16'd0 ||
            bus.out_phase !== 2'd0 || bus.sat_flag !== 1'b0 || bus.drop_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b v=%b d=%0d p=%0d s=%b dr=%b want 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_phase, bus.sat_flag, bus.drop_flag);
        end
        do_reset();
    endtask

    task automatic test_one_block();
        logic [OW-1:0] e [3];
        e[0] = 16'd1;
        e[1] = 16'd2;
        e[2] = 16'd0;
        do_reset();
        bus.out_ready = 1'b1;
        drive_block(64'sd4194304, 64'sd12582912, -64'sd4194304);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e[i] || bus.out_phase !== 2'(i)) begin
                errors++;
                $display("FAIL one_block[%0d] got v=%b d=%0d p=%0d want v=1 d=%0d p=%0d",
                         i, bus.out_valid, bus.out_data, bus.out_phase, e[i], i);
            end
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL one_block_idle got v=%b sat=%b want 0 0", bus.out_valid, bus.sat_flag);
        end
    endtask

    task automatic test_saturation();
        logic [OW-1:0] e [3];
        e[0] = 16'h7fff;
        e[1] = 16'h8000;
        e[2] = 16'h7fff;
        do_reset();
        bus.out_ready = 1'b1;
        drive_block(64'sd1 <<< 40, -(64'sd1 <<< 40), 64'sh7fff <<< 23);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_before got %b want 0", bus.sat_flag);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.out_data !== e[i] || bus.out_phase !== 2'(i) || bus.sat_flag !== 1'b1) begin
                errors++;
                $display("FAIL sat_sample[%0d] got d=%0d p=%0d sat=%b want d=%0d p=%0d sat=1",
                         i, $signed(bus.out_data), bus.out_phase, bus.sat_flag, $signed(e[i]), i);
            end
        end
        bus.flag_clr = 1'b1;
        step();
        bus.flag_clr = 1'b0;
        checks++;
        if (bus.sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear got %b want 0", bus.sat_flag);
        end
    endtask

    task automatic test_backpressure();
        int  cyc;
        bit  done;
        do_reset();
        done = 1'b0;
        for (cyc = 0; cyc < 2000 && !done; cyc++) begin
            if (exp_s.size() < 36 && (cyc % 3) == 0) begin
                drive_block(rand_samp(), rand_samp(), rand_samp());
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = (cyc >= 10 && cyc < 15) ? 1'b0 : ($urandom_range(0, 3) != 0);
            step();
            checks++;
            if (bus.out_valid !== m_valid || bus.out_data !== m_data || bus.out_phase !== m_phase ||
                bus.in_ready !== model_ready() || bus.sat_flag !== m_sat || bus.drop_flag !== m_drop) begin
                errors++;
                $display("FAIL bp_cycle%0d got v=%b d=%h p=%0d r=%b s=%b dr=%b want v=%b d=%h p=%0d r=%b s=%b dr=%b",
                         cyc, bus.out_valid, bus.out_data, bus.out_phase, bus.in_ready, bus.sat_flag,
                         bus.drop_flag, m_valid, m_data, m_phase, model_ready(), m_sat, m_drop);
            end
            if (exp_s.size() == 36 && got_s.size() == 36) done = 1'b1;
        end
        bus.in_valid  = 1'b0;
        checks++;
        if (got_s.size() != 36 || exp_s.size() != 36) begin
            errors++;
            $display("FAIL bp_count got %0d samples want 36 (expected list %0d)", got_s.size(), exp_s.size());
        end else begin
            for (int i = 0; i < 36; i++) begin
                checks++;
                if (got_s[i] !== exp_s[i]) begin
                    errors++;
                    $display("FAIL bp_sample[%0d] got %h want %h", i, got_s[i], exp_s[i]);
                end
            end
        end
    endtask

    task automatic test_full_drop();
        samp_t         blk [6][3];
        logic [OW-1:0] e;
        bit            dummy;
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 3; j++) blk[i][j] = rand_samp();
            drive_block(blk[i][0], blk[i][1], blk[i][2]);
            step();
            checks++;
            if (bus.in_ready !== (i < 3)) begin
                errors++;
                $display("FAIL full_ready[%0d] got %b want %b", i, bus.in_ready, (i < 3));
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.drop_flag !== 1'b1) begin
            errors++;
            $display("FAIL drop_flag got %b want 1", bus.drop_flag);
        end
        bus.out_ready = 1'b1;
        repeat (20) step();
        checks++;
        if (got_s.size() != 12) begin
            errors++;
            $display("FAIL full_count got %0d want 12", got_s.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                e = conv(blk[i / 3][i % 3], dummy);
                checks++;
                if (got_s[i] !== e) begin
                    errors++;
                    $display("FAIL full_sample[%0d] got %h want %h", i, got_s[i], e);
                end
            end
        end
        bus.flag_clr = 1'b1;
        step();
        bus.flag_clr = 1'b0;
    endtask

    task automatic test_wrap();
        int bad_rdy;
        int bad_cont;
        do_reset();
        bus.out_ready = 1'b1;
        bad_rdy  = 0;
        bad_cont = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (cyc < 60 && (cyc % 3) == 0) begin
                drive_block(rand_samp(), rand_samp(), rand_samp());
                if (bus.in_ready !== 1'b1) bad_rdy++;
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            if (cyc >= 1 && cyc <= 60 && bus.out_valid !== 1'b1) bad_cont++;
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL wrap_ready got %0d not-ready cycles want 0", bad_rdy);
        end
        checks++;
        if (bad_cont != 0) begin
            errors++;
            $display("FAIL wrap_continuous got %0d gaps want 0", bad_cont);
        end
        checks++;
        if (bus.drop_flag !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end got drop=%b v=%b want 0 0", bus.drop_flag, bus.out_valid);
        end
        checks++;
        if (got_s.size() != 60 || got_s != exp_s) begin
            errors++;
            $display("FAIL wrap_stream got %0d samples want 60 matching model", got_s.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b0;
        drive_block(64'sd1 <<< 40, 64'sd5, 64'sd6);
        step();
        drive_block(64'sd7, 64'sd8, 64'sd9);
        step();
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got v=%b sat=%b want 1 1", bus.out_valid, bus.sat_flag);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sat_flag !== 1'b0 ||
            bus.drop_flag !== 1'b0 || bus.out_phase !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b rdy=%b s=%b dr=%b p=%0d want 0 1 0 0 0",
                     bus.out_valid, bus.in_ready, bus.sat_flag, bus.drop_flag, bus.out_phase);
        end
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        drive_block(64'sd4194304, 64'sd12582912, -64'sd4194304);
        step();
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_phase !== 2'd0 || bus.out_data !== 16'd1) begin
            errors++;
            $display("FAIL post_reset got v=%b p=%0d d=%0d want 1 0 1",
                     bus.out_valid, bus.out_phase, bus.out_data);
        end
        repeat (3) step();
        checks++;
        if (got_s.size() != 3 || got_s != exp_s) begin
            errors++;
            $display("FAIL post_reset_stream got %0d samples want 3 matching model", got_s.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_one_block();
        test_saturation();
        test_backpressure();
        test_full_drop();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
